// File: rtl/t05_sd_block_parser.sv
`default_nettype none
// ============================================================================
// t05_sd_block_parser : strips start tokens and CRC from an SD CMD18 read
// stream and forwards the data bytes over a valid/ready handshake.
// Revision 1.0
// ============================================================================
module t05_sd_block_parser #(
    parameter int         BLOCK_BYTES   = 512,
    parameter int         CRC_BYTES     = 2,
    parameter logic [7:0] START_TOKEN   = 8'hFE,
    parameter int         TOKEN_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] total_bytes,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_req,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        read_stop,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  err_code,
    output logic [15:0] blocks_done
);

    localparam int c_bcnt_w = $clog2(BLOCK_BYTES) + 1;
    localparam int c_ccnt_w = $clog2(CRC_BYTES) + 1;
    localparam int c_tcnt_w = $clog2(TOKEN_TIMEOUT + 1);

    localparam logic [c_bcnt_w-1:0] c_blk_last = c_bcnt_w'(BLOCK_BYTES - 1);
    localparam logic [c_ccnt_w-1:0] c_crc_last = c_ccnt_w'(CRC_BYTES - 1);
    localparam logic [c_tcnt_w-1:0] c_tmo_last = c_tcnt_w'(TOKEN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_HOLD = 3'd3,
        S_CRC  = 3'd4,
        S_STOP = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_rem;
    logic [c_bcnt_w-1:0]   r_bcnt;
    logic [c_ccnt_w-1:0]   r_ccnt;
    logic [c_tcnt_w-1:0]   r_tcnt;
    logic [7:0]            r_char;
    logic [7:0]            r_err_code;
    logic [15:0]           r_blocks;

    logic w_accept;
    logic w_is_token;
    logic w_is_errtok;
    logic w_tmo;
    logic w_last;
    logic w_blk_end;
    logic w_crc_end;
    logic w_zero_len;

    assign byte_req    = (r_state == S_WAIT) || (r_state == S_DATA) || (r_state == S_CRC);
    assign w_accept    = byte_valid && byte_req;
    assign w_is_token  = (byte_in == START_TOKEN);
    assign w_is_errtok = (byte_in[7:4] == 4'b0000);
    assign w_tmo       = (r_tcnt == c_tmo_last);
    assign w_last      = (r_rem == 32'd1);
    assign w_blk_end   = (r_bcnt == c_blk_last);
    assign w_crc_end   = (r_ccnt == c_crc_last);
    assign w_zero_len  = (total_bytes == 32'd0);

    assign char_out    = r_char;
    assign err_code    = r_err_code;
    assign blocks_done = r_blocks;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        char_valid = 1'b0;
        read_stop  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = w_zero_len ? S_STOP : S_WAIT;
            end
            S_WAIT: begin
                // Any non-token, non-error byte is filler and feeds the timeout.
                if (byte_valid) begin
                    if (w_is_token)       w_next = S_DATA;
                    else if (w_is_errtok) w_next = S_ERR;
                    else if (w_tmo)       w_next = S_ERR;
                end
            end
            S_DATA: begin
                if (byte_valid) w_next = S_HOLD;
            end
            S_HOLD: begin
                char_valid = 1'b1;
                if (char_ready) begin
                    if (w_last)         w_next = S_STOP;
                    else if (w_blk_end) w_next = S_CRC;
                    else                w_next = S_DATA;
                end
            end
            S_CRC: begin
                if (byte_valid && w_crc_end) w_next = S_WAIT;
            end
            S_STOP: begin
                read_stop = 1'b1;
                w_next    = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                read_stop = 1'b1;
                if (start) w_next = w_zero_len ? S_STOP : S_WAIT;
            end
            S_ERR: begin
                busy      = 1'b0;
                error     = 1'b1;
                read_stop = 1'b1;
                if (start) w_next = w_zero_len ? S_STOP : S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem      <= '0;
            r_bcnt     <= '0;
            r_ccnt     <= '0;
            r_tcnt     <= '0;
            r_char     <= '0;
            r_err_code <= '0;
            r_blocks   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_rem      <= total_bytes;
                        r_err_code <= '0;
                        r_blocks   <= '0;
                        r_tcnt     <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        if (w_is_token) begin
                            r_bcnt <= '0;
                        end else if (w_is_errtok) begin
                            r_err_code <= byte_in;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                            if (w_tmo) r_err_code <= 8'hFF;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) r_char <= byte_in;
                end
                S_HOLD: begin
                    if (char_ready) begin
                        if (r_rem != 32'd0) r_rem <= r_rem - 32'd1;
                        r_bcnt <= r_bcnt + 1'b1;
                        if (!w_last && w_blk_end) r_ccnt <= '0;
                    end
                end
                S_CRC: begin
                    if (w_accept) begin
                        r_ccnt <= r_ccnt + 1'b1;
                        if (w_crc_end) begin
                            if (r_blocks != 16'hFFFF) r_blocks <= r_blocks + 16'd1;
                            r_tcnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t05_sd_block_parser.sv
`default_nettype none
// Self-checking bench for t05_sd_block_parser: directed table, corner-case
// sequences and randomized streams against a block-level reference model.
module tb_t05_sd_block_parser;

    localparam int BB = 4;
    localparam int CB = 2;
    localparam int TT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] total_bytes = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        char_ready = 1'b0;
    logic        byte_req;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        read_stop;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  err_code;
    logic [15:0] blocks_done;

    t05_sd_block_parser #(
        .BLOCK_BYTES  (BB),
        .CRC_BYTES    (CB),
        .START_TOKEN  (8'hFE),
        .TOKEN_TIMEOUT(TT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .total_bytes(total_bytes),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_req   (byte_req),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .read_stop  (read_stop),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [31:0]  total;
        int           slen;
        logic [127:0] s;
        int           nexp;
        logic [63:0]  e;
        logic         exp_err;
        logic [7:0]   code;
        logic [15:0]  blocks;
    } vec_t;

    vec_t       tab [7];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] got [$];
    int         n_in;
    int         cycles;
    int         stall_cnt;
    logic       req_seen;
    logic       bp_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic [31:0] tot, input int sl,
                                input logic [127:0] s, input int ne, input logic [63:0] e,
                                input logic er, input logic [7:0] cd, input logic [15:0] bl);
        vec_t v;
        v.name = nm; v.total = tot; v.slen = sl; v.s = s; v.nexp = ne; v.e = e;
        v.exp_err = er; v.code = cd; v.blocks = bl;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] tot);
        start       = 1'b1;
        total_bytes = tot;
        byte_valid  = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // Streams s (first byte most significant) until done/error, optionally
    // stalling char_ready for stall_n cycles while stall_char is presented.
    task automatic run_feed(input logic [127:0] s, input int slen,
                            input logic [7:0] stall_char, input int stall_n);
        logic       acc;
        logic       hs;
        logic [7:0] co;
        got.delete();
        n_in = 0; cycles = 0; stall_cnt = 0; req_seen = 1'b0; bp_ok = 1'b1;
        while (!(done || error) && cycles < 200) begin
            byte_valid = (n_in < slen);
            byte_in    = 8'h00;
            if (n_in < slen) byte_in = s[8*(slen-1-n_in) +: 8];
            if (char_valid && char_out == stall_char && stall_cnt < stall_n) begin
                char_ready = 1'b0;
                stall_cnt++;
                if (byte_req !== 1'b0 || char_valid !== 1'b1) bp_ok = 1'b0;
            end else begin
                char_ready = 1'b1;
            end
            if (byte_req) req_seen = 1'b1;
            acc = byte_valid && byte_req;
            hs  = char_valid && char_ready;
            co  = char_out;
            tick();
            if (acc) n_in++;
            if (hs) got.push_back(co);
            cycles++;
        end
        byte_valid = 1'b0;
        char_ready = 1'b0;
        check("feed_cycle_bound", 32'(cycles < 200), 32'd1);
    endtask

    task automatic run_case(input vec_t v);
        pulse_start(v.total);
        run_feed(v.s, v.slen, 8'h00, 0);
        check({v.name, "_nchars"}, 32'(got.size()), 32'(v.nexp));
        for (int i = 0; i < v.nexp; i++)
            if (i < got.size()) check({v.name, "_char"}, 32'(got[i]), 32'(v.e[8*(v.nexp-1-i) +: 8]));
        check({v.name, "_done"}, 32'(done), 32'(!v.exp_err));
        check({v.name, "_error"}, 32'(error), 32'(v.exp_err));
        check({v.name, "_err_code"}, 32'(err_code), 32'(v.code));
        check({v.name, "_blocks"}, 32'(blocks_done), 32'(v.blocks));
        check({v.name, "_read_stop"}, 32'(read_stop), 32'd1);
        check({v.name, "_busy"}, 32'(busy), 32'd0);
        if (v.total == 0) begin
            check("zero_len_no_req", 32'(req_seen), 32'd0);
            check("zero_len_latency", 32'(cycles <= 2), 32'd1);
        end
    endtask

    task automatic run_random(input int iters);
        int         n, nblk, err_at, nf, got_n, idx, cyc;
        logic [7:0] etok, d;
        logic       acc, hs;
        logic [7:0] co;
        logic [7:0] strm [$];
        logic [7:0] expq [$];
        for (int it = 0; it < iters; it++) begin
            strm.delete();
            expq.delete();
            n      = $urandom_range(1, 22);
            nblk   = (n + BB - 1) / BB;
            err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nblk - 1) : -1;
            etok   = 8'($urandom_range(0, 15));
            for (int b = 0; b < nblk; b++) begin
                nf = $urandom_range(0, TT - 1);
                for (int f = 0; f < nf; f++)
                    strm.push_back(($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(8'h10, 8'hFD)));
                if (b == err_at) begin
                    strm.push_back(etok);
                    break;
                end
                strm.push_back(8'hFE);
                for (int k = 0; k < BB; k++) begin
                    d = 8'($urandom_range(0, 255));
                    strm.push_back(d);
                    if (b * BB + k < n) expq.push_back(d);
                end
                for (int k = 0; k < CB; k++) strm.push_back(8'($urandom_range(0, 255)));
            end
            pulse_start(32'(n));
            idx = 0; cyc = 0; got_n = 0;
            while (!(done || error) && cyc < 1000) begin
                byte_valid = (idx < strm.size()) && ($urandom_range(0, 3) != 0);
                byte_in    = (idx < strm.size()) ? strm[idx] : 8'h00;
                char_ready = ($urandom_range(0, 2) != 0);
                acc = byte_valid && byte_req;
                hs  = char_valid && char_ready;
                co  = char_out;
                tick();
                if (acc) idx++;
                if (hs) begin
                    if (got_n < expq.size()) check("rnd_char", 32'(co), 32'(expq[got_n]));
                    else check("rnd_extra_char", 32'(got_n), 32'(expq.size()));
                    got_n++;
                end
                cyc++;
            end
            byte_valid = 1'b0;
            char_ready = 1'b0;
            check("rnd_cycle_bound", 32'(cyc < 1000), 32'd1);
            check("rnd_nchars", 32'(got_n), 32'(expq.size()));
            check("rnd_error", 32'(error), 32'(err_at >= 0));
            check("rnd_done", 32'(done), 32'(err_at < 0));
            check("rnd_err_code", 32'(err_code), (err_at >= 0) ? 32'(etok) : 32'd0);
            check("rnd_blocks", 32'(blocks_done), (err_at >= 0) ? 32'(err_at) : 32'((n - 1) / BB));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tab[0] = mk("basic", 32'd4, 7, 128'({8'hFF, 8'hFF, 8'hFE, 8'h41, 8'h42, 8'h43, 8'h44}),
                    4, 64'({8'h41, 8'h42, 8'h43, 8'h44}), 1'b0, 8'h00, 16'd0);
        tab[1] = mk("block_bnd", 32'd6, 11,
                    128'({8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC1, 8'hC2, 8'hFF, 8'hFE, 8'h05, 8'h06}),
                    6, 64'({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}), 1'b0, 8'h00, 16'd1);
        tab[2] = mk("err_token", 32'd4, 2, 128'({8'hFF, 8'h05}), 0, 64'd0, 1'b1, 8'h05, 16'd0);
        tab[3] = mk("timeout", 32'd4, 3, 128'({8'hFF, 8'hFF, 8'hFF}), 0, 64'd0, 1'b1, 8'hFF, 16'd0);
        tab[4] = mk("zero_len", 32'd0, 0, 128'd0, 0, 64'd0, 1'b0, 8'h00, 16'd0);
        tab[5] = mk("filler_mix", 32'd3, 6, 128'({8'h80, 8'hFF, 8'hFE, 8'hFE, 8'h00, 8'hFF}),
                    3, 64'({8'hFE, 8'h00, 8'hFF}), 1'b0, 8'h00, 16'd0);
        tab[6] = mk("err_after_blk", 32'd8, 8,
                    128'({8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC1, 8'hC2, 8'h0B}),
                    4, 64'({8'h11, 8'h22, 8'h33, 8'h44}), 1'b1, 8'h0B, 16'd1);

        // Reset state
        #2;
        check("reset_outputs",
              32'({byte_req, char_valid, read_stop, busy, done, error, char_out, err_code, blocks_done}),
              32'd0);
        #1 rst = 1'b0;
        tick();

        // start coincident with byte_valid in IDLE: the byte must be dropped
        start = 1'b1; total_bytes = 32'd1; byte_valid = 1'b1; byte_in = 8'hFE;
        #1 check("idle_byte_req", 32'(byte_req), 32'd0);
        tick();
        start = 1'b0; byte_valid = 1'b0;
        check("idle_start_busy", 32'(busy), 32'd1);
        run_feed(128'({8'hFE, 8'h77}), 2, 8'h00, 0);
        check("idle_start_nchars", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("idle_start_char", 32'(got[0]), 32'h77);
        check("idle_start_done", 32'(done), 32'd1);

        for (int i = 0; i < 7; i++) run_case(tab[i]);

        // Backpressure on the second character
        pulse_start(32'd4);
        run_feed(tab[0].s, 7, 8'h42, 5);
        check("bp_stall_cycles", 32'(stall_cnt), 32'd5);
        check("bp_hold_stable", 32'(bp_ok), 32'd1);
        check("bp_nchars", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check("bp_char", 32'(got[i]), 32'(8'h41 + i));
        check("bp_done", 32'(done), 32'd1);

        // start while busy is ignored
        pulse_start(32'd2);
        start = 1'b1; total_bytes = 32'd0;
        tick();
        start = 1'b0;
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_stop", 32'(read_stop | done), 32'd0);
        run_feed(128'({8'hFE, 8'hAA, 8'hBB}), 3, 8'h00, 0);
        check("busy_start_nchars", 32'(got.size()), 32'd2);
        if (got.size() > 1) check("busy_start_char", 32'({got[0], got[1]}), 32'hAABB);
        check("busy_start_done", 32'(done), 32'd1);

        // Asynchronous reset while holding a character
        pulse_start(32'd4);
        char_ready = 1'b0; byte_valid = 1'b1; byte_in = 8'hFE;
        tick();
        byte_in = 8'h41;
        tick();
        byte_valid = 1'b0;
        check("hold_char_valid", 32'(char_valid), 32'd1);
        check("hold_char_out", 32'(char_out), 32'h41);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs",
                 32'({byte_req, char_valid, read_stop, busy, done, error, char_out, err_code, blocks_done}),
                 32'd0);
        #2 rst = 1'b0;
        tick();
        run_case(tab[0]);

        run_random(25);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
